// File: rtl/lms_fifo_ctrl_if.sv
// lms_fifo_ctrl_if: bundles the FIFO push/pop/status signals and the
// external SDP RAM port; master = FIFO user + RAM, slave = controller.
interface lms_fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   wr_water_level;
    logic                  wr_err;
    logic                  rd_err;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    modport master (
        output wr_en, wr_data, rd_en, mem_rd_data,
        input  rd_data, rd_valid, full, empty,
        input  almost_full, almost_empty, wr_water_level,
        input  wr_err, rd_err,
        input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr
    );

    modport slave (
        input  wr_en, wr_data, rd_en, mem_rd_data,
        output rd_data, rd_valid, full, empty,
        output almost_full, almost_empty, wr_water_level,
        output wr_err, rd_err,
        output mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr
    );
endinterface

// File: rtl/lms_fifo_ctrl.sv
// lms_fifo_ctrl: single-clock FIFO controller driving an external
// distributed SDP RAM (combinational read, OUT_REG=0).
// Ports: clk, rst (sync, active-high), bus (lms_fifo_ctrl_if.slave):
//   wr_en/wr_data push, rd_en pop, rd_data/rd_valid (1-cycle latency),
//   full/empty, almost_full/almost_empty, wr_water_level (count),
//   wr_err/rd_err (rejected push/pop), mem_* RAM port.
// Macro LMS_FIFO_ALMOST_FLAGS_EN enables the almost_* threshold logic;
// without it almost_full/almost_empty are tied to 0.
module lms_fifo_ctrl #(
    parameter int ADDR_WIDTH       = 4,
    parameter int DATA_WIDTH       = 16,
    parameter int ALMOST_FULL_NUM  = 2**ADDR_WIDTH-2,
    parameter int ALMOST_EMPTY_NUM = 2
) (
    input logic            clk,
    input logic            rst,
    lms_fifo_ctrl_if.slave bus
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    typedef logic [ADDR_WIDTH:0] ptr_t;

    // Parameter sanity, evaluated at elaboration only.
    if (ADDR_WIDTH < 4 || ADDR_WIDTH > 10) begin : g_bad_aw
        $error("lms_fifo_ctrl: ADDR_WIDTH out of range 4..10");
    end
    if (DATA_WIDTH < 1 || DATA_WIDTH > 256) begin : g_bad_dw
        $error("lms_fifo_ctrl: DATA_WIDTH out of range 1..256");
    end
    if (ALMOST_FULL_NUM < 0 || ALMOST_FULL_NUM > DEPTH ||
        ALMOST_EMPTY_NUM < 0 || ALMOST_EMPTY_NUM > DEPTH) begin : g_bad_th
        $error("lms_fifo_ctrl: almost threshold out of range");
    end

    ptr_t                  wr_ptr;
    ptr_t                  rd_ptr;
    ptr_t                  wr_ptr_n;
    ptr_t                  rd_ptr_n;
    ptr_t                  cnt_n;
    ptr_t                  cnt_q;
    logic                  full_c;
    logic                  empty_c;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  wr_err_q;
    logic                  rd_err_q;

    // Extra MSB on each pointer separates full from empty.
    assign full_c  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                     (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign empty_c = (wr_ptr == rd_ptr);

    // Reset blocks both accepts so the RAM is never written under rst.
    assign wr_acc = bus.wr_en & ~full_c & ~rst;
    assign rd_acc = bus.rd_en & ~empty_c & ~rst;

    assign wr_ptr_n = wr_ptr + ptr_t'(wr_acc);
    assign rd_ptr_n = rd_ptr + ptr_t'(rd_acc);
    assign cnt_n    = wr_ptr_n - rd_ptr_n;

    assign bus.mem_wr_en   = wr_acc;
    assign bus.mem_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign bus.mem_wr_data = bus.wr_data;
    assign bus.mem_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_err_q   <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            cnt_q      <= cnt_n;
            rd_valid_q <= rd_acc;
            wr_err_q   <= bus.wr_en & full_c;
            rd_err_q   <= bus.rd_en & empty_c;
            if (rd_acc) begin
                rd_data_q <= bus.mem_rd_data;
            end
        end
    end

    assign bus.full           = full_c;
    assign bus.empty          = empty_c;
    assign bus.wr_water_level = cnt_q;
    assign bus.rd_data        = rd_data_q;
    assign bus.rd_valid       = rd_valid_q;
    assign bus.wr_err         = wr_err_q;
    assign bus.rd_err         = rd_err_q;

`ifdef LMS_FIFO_ALMOST_FLAGS_EN
    localparam ptr_t AF_TH = ptr_t'(ALMOST_FULL_NUM);
    localparam ptr_t AE_TH = ptr_t'(ALMOST_EMPTY_NUM);

    logic af_q;
    logic ae_q;

    // Driven from the next count so the flags change with wr_water_level.
    always_ff @(posedge clk) begin
        if (rst) begin
            af_q <= 1'b0;
            ae_q <= 1'b1;
        end else begin
            af_q <= (cnt_n >= AF_TH);
            ae_q <= (cnt_n <= AE_TH);
        end
    end

    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
`else
    assign bus.almost_full  = 1'b0;
    assign bus.almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_lms_fifo_ctrl.sv
// tb_lms_fifo_ctrl: scoreboard bench for lms_fifo_ctrl with a queue-based
// reference model and a behavioural SDP RAM.
module tb_lms_fifo_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AF_N  = DEPTH - 2;
    localparam int AE_N  = 2;

    typedef struct {
        int          cnt;
        logic        full;
        logic        empty;
        logic        af;
        logic        ae;
        logic        werr;
        logic        rerr;
        logic        vld;
        logic [15:0] rdd;
    } st_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lms_fifo_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    lms_fifo_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (bus_if.mem_wr_en) ram[bus_if.mem_wr_addr] <= bus_if.mem_wr_data;
    end
    assign bus_if.mem_rd_data = ram[bus_if.mem_rd_addr];

    int errors = 0;
    int checks = 0;

    st_t         st_q[$];
    logic [15:0] dq[$];
    logic [15:0] model[$];
    logic [15:0] last_rd = '0;
    int          wr_idx = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, predict the post-edge state, and
    // hand the prediction to the monitor.
    task automatic cycle(input logic r, input logic we,
                         input logic [15:0] wd, input logic re);
        st_t e;
        logic wacc;
        logic racc;
        rst            = r;
        bus_if.wr_en   = we;
        bus_if.wr_data = wd;
        bus_if.rd_en   = re;
        e.werr = 1'b0;
        e.rerr = 1'b0;
        e.vld  = 1'b0;
        wacc   = 1'b0;
        racc   = 1'b0;
        if (r) begin
            model.delete();
            last_rd = '0;
        end else begin
            wacc   = we && (model.size() < DEPTH);
            racc   = re && (model.size() > 0);
            e.werr = we && (model.size() == DEPTH);
            e.rerr = re && (model.size() == 0);
            if (racc) begin
                last_rd = model.pop_front();
                dq.push_back(last_rd);
            end
            if (wacc) model.push_back(wd);
        end
        e.vld   = racc;
        e.rdd   = last_rd;
        e.cnt   = model.size();
        e.full  = (e.cnt == DEPTH);
        e.empty = (e.cnt == 0);
`ifdef LMS_FIFO_ALMOST_FLAGS_EN
        e.af = (e.cnt >= AF_N);
        e.ae = (e.cnt <= AE_N);
`else
        e.af = 1'b0;
        e.ae = 1'b0;
`endif
        st_q.push_back(e);
        #1;
        chk("mem_wr_en", 32'(bus_if.mem_wr_en), 32'(wacc));
        if (wacc) chk("mem_wr_addr", 32'(bus_if.mem_wr_addr), 32'(wr_idx % DEPTH));
        if (r) wr_idx = 0;
        else if (wacc) wr_idx++;
        @(negedge clk);
    endtask

    // Monitor: compares DUT state just after each rising edge.
    initial begin
        st_t e;
        forever begin
            @(posedge clk);
            #1;
            if (st_q.size() != 0) begin
                e = st_q.pop_front();
                chk("count", 32'(bus_if.wr_water_level), 32'(e.cnt));
                chk("full", 32'(bus_if.full), 32'(e.full));
                chk("empty", 32'(bus_if.empty), 32'(e.empty));
                chk("almost_full", 32'(bus_if.almost_full), 32'(e.af));
                chk("almost_empty", 32'(bus_if.almost_empty), 32'(e.ae));
                chk("wr_err", 32'(bus_if.wr_err), 32'(e.werr));
                chk("rd_err", 32'(bus_if.rd_err), 32'(e.rerr));
                chk("rd_valid", 32'(bus_if.rd_valid), 32'(e.vld));
                chk("rd_data_hold", 32'(bus_if.rd_data), 32'(e.rdd));
            end
            if (bus_if.rd_valid === 1'b1) begin
                if (dq.size() == 0) begin
                    chk("unexpected_rd_valid", 32'(bus_if.rd_valid), 32'd0);
                end else begin
                    chk("rd_data_order", 32'(bus_if.rd_data), 32'(dq.pop_front()));
                end
            end
        end
    end

    initial begin
        bus_if.wr_en   = 1'b0;
        bus_if.wr_data = '0;
        bus_if.rd_en   = 1'b0;

        // Reset state.
        cycle(1, 0, 16'h0, 0);
        cycle(1, 1, 16'h0bad, 1);

        // Fill, overflow attempt, drain, underflow attempt.
        for (int i = 1; i <= DEPTH; i++) cycle(0, 1, 16'(i), 0);
        cycle(0, 1, 16'hdead, 0);
        cycle(0, 1, 16'hbeef, 1);
        cycle(0, 1, 16'h0011, 0);
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 16'h0, 1);
        cycle(0, 0, 16'h0, 1);
        cycle(0, 0, 16'h0, 0);

        // Steady count of 8 with simultaneous push/pop; pointers wrap.
        for (int i = 0; i < 8; i++) cycle(0, 1, 16'($urandom), 0);
        for (int i = 0; i < 40; i++) cycle(0, 1, 16'($urandom), 1);
        for (int i = 0; i < 8; i++) cycle(0, 0, 16'h0, 1);

        // Reset mid-stream at count 5, then new traffic.
        for (int i = 0; i < 5; i++) cycle(0, 1, 16'(16'h100 + i), 0);
        cycle(1, 1, 16'hffff, 1);
        cycle(0, 1, 16'h1234, 0);
        cycle(0, 0, 16'h0, 1);
        cycle(0, 0, 16'h0, 0);

        // Random traffic, push-biased then pop-biased, rare resets.
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 300; i++) begin
                logic we;
                logic re;
                logic r;
                we = ($urandom_range(0, 99) < ((p == 0) ? 75 : 30));
                re = ($urandom_range(0, 99) < ((p == 0) ? 30 : 75));
                r  = ($urandom_range(0, 99) < 2);
                cycle(r, we, 16'($urandom), re);
            end
        end
        cycle(0, 0, 16'h0, 0);

        chk("status_queue_drained", 32'(st_q.size()), 32'd0);
        chk("data_queue_drained", 32'(dq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lms_fifo_ctrl.md
LMS_FIFO_CTRL -- requirements
Module: lms_fifo_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: memory address width, range 4-10; depth is 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: word width, range 1-256.
REQ-003 SHALL have parameter ALMOST_FULL_NUM, default 2**ADDR_WIDTH-2: almost_full threshold in words.
REQ-004 SHALL have parameter ALMOST_EMPTY_NUM, default 2: almost_empty threshold in words.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port wr_en, input, 1: push request.
REQ-008 SHALL have port wr_data, input, DATA_WIDTH: push data.
REQ-009 SHALL have port rd_en, input, 1: pop request.
REQ-010 SHALL have port rd_data, output, DATA_WIDTH: registered pop data.
REQ-011 SHALL have port rd_valid, output, 1: rd_data was updated this cycle.
REQ-012 SHALL have ports full and empty, output, 1 each: status flags.
REQ-013 SHALL have ports almost_full and almost_empty, output, 1 each: threshold flags.
REQ-014 SHALL have port wr_water_level, output, ADDR_WIDTH+1: current word count.
REQ-015 SHALL have ports wr_err and rd_err, output, 1 each: rejected push or pop.
REQ-016 SHALL have ports mem_wr_en (1), mem_wr_addr (ADDR_WIDTH), mem_wr_data (DATA_WIDTH) and mem_rd_addr (ADDR_WIDTH), all outputs, to the external distributed SDP RAM.
REQ-017 SHALL have port mem_rd_data, input, DATA_WIDTH: combinational RAM read data; the RAM runs with OUT_REG=0 and both RAM clocks tied to clk.

Function
REQ-018 SHALL accept a push iff wr_en=1 and full=0; mem_wr_en SHALL equal that accept signal combinationally.
REQ-019 SHALL drive mem_wr_addr from wr_ptr[ADDR_WIDTH-1:0] and mem_wr_data from wr_data, both combinationally.
REQ-020 SHALL accept a pop iff rd_en=1 and empty=0; mem_rd_addr SHALL equal rd_ptr[ADDR_WIDTH-1:0].
REQ-021 SHALL keep wr_ptr and rd_ptr ADDR_WIDTH+1 bits wide, increment each by 1 on accept, and wrap modulo 2**(ADDR_WIDTH+1).
REQ-022 SHALL assert full when the pointer MSBs differ and the low bits are equal, and assert empty when the pointers are equal.
REQ-023 SHALL set wr_water_level to wr_ptr-rd_ptr, range 0..2**ADDR_WIDTH, registered and consistent with the flags every cycle.
REQ-024 SHALL, on an accepted pop, load rd_data <= mem_rd_data at the next edge and pulse rd_valid for 1 cycle; otherwise rd_data holds its value (latency 1).
REQ-025 SHALL accept both a push and a pop in the same cycle when neither is blocked; the count is unchanged.
REQ-026 SHALL reject a push when full even if a pop is accepted in the same cycle; a pop when empty is always rejected, so a same-address read/write collision never occurs.
REQ-027 SHALL register wr_err=1 for one cycle after a rejected push (wr_en=1 and full=1), and rd_err=1 likewise for a rejected pop (rd_en=1 and empty=1).
REQ-028 SHALL assert almost_full when count >= ALMOST_FULL_NUM and almost_empty when count <= ALMOST_EMPTY_NUM; both are registered and updated in the same cycle as the count.

Reset
REQ-029 SHALL, when rst=1 at a clock edge, clear wr_ptr, rd_ptr, wr_water_level, rd_data, rd_valid, wr_err, rd_err, full, almost_full, and set empty=1 and almost_empty=1.
REQ-030 SHALL give rst priority over a simultaneous push or pop; RAM contents are not cleared, and mem_wr_en=0 while rst=1.

Configuration
REQ-031 SHALL, with macro LMS_FIFO_ALMOST_FLAGS_EN defined, implement almost_full and almost_empty per REQ-028.
REQ-032 SHALL, without LMS_FIFO_ALMOST_FLAGS_EN, omit the threshold logic, tie almost_full=0 and almost_empty=0, and keep the ports present.

Verification (ADDR_WIDTH=4, DATA_WIDTH=16, macro defined unless stated)
REQ-033 SHALL cover: push 0x0001..0x0010 -> full=1 after the 16th push, wr_water_level=16, almost_full=1 from count 14.
REQ-034 SHALL cover: pop 16 times after the fill -> rd_data 0x0001..0x0010 in order, each one cycle after rd_en, and empty=1 after the last pop.
REQ-035 SHALL cover: push while full, then pop while empty -> wr_err pulse and rd_err pulse, with pointers and count unchanged.
REQ-036 SHALL cover: count=8, simultaneous push/pop for 40 cycles -> count stays 8, pointers wrap, and data order is preserved.
REQ-037 SHALL cover: assert rst mid-stream at count=5 -> next cycle empty=1, count=0, rd_data=0, and a following push/pop returns the new data.
REQ-038 SHALL cover: build without the macro -> almost_full=0 and almost_empty=0 throughout REQ-033.
